// File: rtl/turret_button_scheduler.sv
// Turret button front-end: tick-sampled debounce, per-button press/hold/repeat
// FSMs, one-deep pending slots and a round-robin arbiter onto a valid/ready port.
module turret_button_scheduler #(
  parameter int N_BTN = 5,
  parameter int DIV = 2,
  parameter int DEB_LEN = 8,
  parameter int HOLD_DLY = 30,
  parameter int RPT_PER = 6,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b01111,
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic [N_BTN-1:0] in_button,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ID_W-1:0]  cmd_id,
  output logic             cmd_repeat,
  output logic [N_BTN-1:0] btn_level,
  output logic             drop_pulse
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_MAX = (HOLD_DLY > RPT_PER) ? HOLD_DLY : RPT_PER;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RPT  = 2'd2
  } state_t;

  // Index base+k modulo N_BTN; base and k are both below N_BTN.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_BTN) s = s - N_BTN;
    return ID_W'(s);
  endfunction

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  logic [DEB_LEN-1:0] hist_q [N_BTN];
  logic [DEB_LEN-1:0] hist_d [N_BTN];
  logic [N_BTN-1:0]   level_q, level_d;
  state_t             st_q [N_BTN];
  state_t             st_d [N_BTN];
  logic [CNT_W-1:0]   cnt_q [N_BTN];
  logic [CNT_W-1:0]   cnt_d [N_BTN];
  logic [N_BTN-1:0]   ev, ev_rpt;
  logic [N_BTN-1:0]   pend_q, pend_d, pend_rpt_q, pend_rpt_d;
  logic [N_BTN-1:0]   grant;
  logic               drop_any;
  logic [ID_W-1:0]    sel;
  logic               found, load;
  logic               valid_q, valid_d, rep_q, rep_d;
  logic [ID_W-1:0]    id_q, id_d, rr_q, rr_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Debounce: level flips only on a full run of equal samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      hist_d[i] = tick ? {hist_q[i][DEB_LEN-2:0], in_button[i]} : hist_q[i];
      if (&hist_d[i]) level_d[i] = 1'b1;
      else if (~|hist_d[i]) level_d[i] = 1'b0;
    end
  end

  always_comb begin
    ev = '0;
    ev_rpt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        S_IDLE: begin
          if (level_q[i]) begin
            ev[i] = 1'b1;
            st_d[i] = S_WAIT;
            cnt_d[i] = '0;
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (!level_q[i]) begin
              st_d[i] = S_IDLE;
            end else if (REPEAT_MASK[i] && (cnt_q[i] == HOLD_LAST)) begin
              ev[i] = 1'b1;
              ev_rpt[i] = 1'b1;
              cnt_d[i] = '0;
              st_d[i] = S_RPT;
            end else if (REPEAT_MASK[i]) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        S_RPT: begin
          if (tick) begin
            if (!level_q[i]) begin
              st_d[i] = S_IDLE;
            end else if (cnt_q[i] == RPT_LAST) begin
              ev[i] = 1'b1;
              ev_rpt[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  // Round-robin pick: first pending slot at or after the pointer.
  always_comb begin
    sel = '0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!found && pend_q[wrap_inc(rr_q, k)]) begin
        found = 1'b1;
        sel = wrap_inc(rr_q, k);
      end
    end
    load = found & (~valid_q | cmd_ready);
    for (int i = 0; i < N_BTN; i++) begin
      grant[i] = load & (sel == ID_W'(i));
    end
  end

  // A slot being granted this cycle may be refilled without loss.
  always_comb begin
    pend_d = pend_q;
    pend_rpt_d = pend_rpt_q;
    drop_any = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (ev[i]) begin
        if (pend_q[i] && !grant[i]) begin
          drop_any = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          pend_rpt_d[i] = ev_rpt[i];
        end
      end else if (grant[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    id_d = id_q;
    rep_d = rep_q;
    rr_d = rr_q;
    if (load) begin
      valid_d = 1'b1;
      id_d = sel;
      rep_d = pend_rpt_q[sel];
      rr_d = wrap_inc(sel, 1);
    end else if (cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      div_q <= '0;
      level_q <= '0;
      pend_q <= '0;
      pend_rpt_q <= '0;
      valid_q <= 1'b0;
      id_q <= '0;
      rep_q <= 1'b0;
      rr_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= '0;
        st_q[i] <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      div_q <= div_d;
      level_q <= level_d;
      pend_q <= pend_d;
      pend_rpt_q <= pend_rpt_d;
      valid_q <= valid_d;
      id_q <= id_d;
      rep_q <= rep_d;
      rr_q <= rr_d;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= hist_d[i];
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_id = id_q;
  assign cmd_repeat = rep_q;
  assign btn_level = level_q;
  assign drop_pulse = drop_any & ~reset;

endmodule

// File: tb/tb_turret_button_scheduler.sv
// Bench for turret_button_scheduler: directed scenarios plus random stimulus,
// every cycle compared against a tick/run-length/age based reference model.
module tb_turret_button_scheduler;

  localparam int N = 5;
  localparam int DIV = 2;
  localparam int DEB = 8;
  localparam int HOLD = 30;
  localparam int RPT = 6;
  localparam bit [N-1:0] MASK = 5'b01111;

  logic fclk;
  logic rst;
  logic rdy;
  logic [N-1:0] btn;
  logic cmd_valid, cmd_repeat, drop_pulse;
  logic [2:0] cmd_id;
  logic [N-1:0] btn_level;

  turret_button_scheduler #(
    .N_BTN(N), .DIV(DIV), .DEB_LEN(DEB), .HOLD_DLY(HOLD), .RPT_PER(RPT), .REPEAT_MASK(MASK)
  ) dut (
    .fclk(fclk),
    .reset(rst),
    .in_button(btn),
    .cmd_valid(cmd_valid),
    .cmd_ready(rdy),
    .cmd_id(cmd_id),
    .cmd_repeat(cmd_repeat),
    .btn_level(btn_level),
    .drop_pulse(drop_pulse)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int total = 0;
  int bad = 0;
  int t_now = 0;
  int drop_cnt = 0;
  int log_id[$];
  int log_rpt[$];
  int log_t[$];

  // Reference model state
  int m_cyc;
  bit m_tick;
  bit m_lvl[N];
  bit m_run_val[N];
  int m_run_len[N];
  bit m_held[N];
  int m_age[N];
  bit m_pend[N];
  bit m_prpt[N];
  bit m_valid, m_rep;
  int m_id, m_rr;
  bit e_ev[N];
  bit e_rpt[N];
  bit e_load, e_drop;
  int e_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 0; m_run_val[i] = 0; m_run_len[i] = DEB;
      m_held[i] = 0; m_age[i] = 0; m_pend[i] = 0; m_prpt[i] = 0;
    end
    m_valid = 0; m_rep = 0; m_id = 0; m_rr = 0;
  endtask

  task automatic model_comb();
    bit any;
    int a, j;
    m_tick = ((m_cyc % DIV) == DIV - 1);
    e_drop = 0; e_load = 0; e_sel = 0; any = 0;
    for (int i = 0; i < N; i++) begin
      e_ev[i] = 0; e_rpt[i] = 0;
      if (m_lvl[i] && !m_held[i]) begin
        e_ev[i] = 1;
      end else if (m_held[i] && m_tick && m_lvl[i] && MASK[i]) begin
        a = m_age[i] + 1;
        if (a >= HOLD && ((a - HOLD) % RPT) == 0) begin
          e_ev[i] = 1; e_rpt[i] = 1;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (!any && m_pend[j]) begin any = 1; e_sel = j; end
    end
    e_load = any && (!m_valid || rdy);
    for (int i = 0; i < N; i++)
      if (e_ev[i] && m_pend[i] && !(e_load && e_sel == i)) e_drop = 1;
    if (rst) e_drop = 0;
  endtask

  task automatic model_adv();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_lvl[i] && !m_held[i]) begin
        m_held[i] = 1; m_age[i] = 0;
      end else if (m_held[i] && m_tick) begin
        if (!m_lvl[i]) m_held[i] = 0;
        else m_age[i]++;
      end
      if (m_tick) begin
        if (btn[i] == m_run_val[i]) begin
          if (m_run_len[i] < DEB) m_run_len[i]++;
        end else begin
          m_run_val[i] = btn[i]; m_run_len[i] = 1;
        end
        if (m_run_len[i] == DEB) m_lvl[i] = m_run_val[i];
      end
    end
    if (e_load) begin
      m_valid = 1; m_id = e_sel; m_rep = m_prpt[e_sel]; m_rr = (e_sel + 1) % N;
    end else if (rdy) begin
      m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (e_ev[i]) begin
        if (!(m_pend[i] && !(e_load && e_sel == i))) begin
          m_pend[i] = 1; m_prpt[i] = e_rpt[i];
        end
      end else if (e_load && e_sel == i) begin
        m_pend[i] = 0;
      end
    end
    m_cyc++;
  endtask

  // One fclk cycle: compare with the model, log handshakes, advance.
  task automatic step();
    bit [N-1:0] lv;
    #1;
    model_comb();
    for (int i = 0; i < N; i++) lv[i] = m_lvl[i];
    chk("cmd_valid", cmd_valid, m_valid);
    chk("cmd_id", cmd_id, m_id);
    chk("cmd_repeat", cmd_repeat, m_rep);
    chk("btn_level", btn_level, lv);
    chk("drop_pulse", drop_pulse, e_drop);
    if (cmd_valid === 1'b1 && rdy === 1'b1) begin
      log_id.push_back(int'(cmd_id));
      log_rpt.push_back(int'(cmd_repeat));
      log_t.push_back(t_now);
    end
    if (drop_pulse === 1'b1) drop_cnt++;
    model_adv();
    t_now++;
    @(negedge fclk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, guard, d0, b;
    bit have;
    logic [2:0] hid;
    logic hr;
    rst = 1'b1; rdy = 1'b0; btn = '0;
    model_reset();
    @(negedge fclk);
    run(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_drop", drop_pulse, 0);

    // Single press from reset release: level at cycle 16, command at 18
    rst = 1'b0; rdy = 1'b1; btn = 5'b00001;
    for (int t = 0; t < 46; t++) begin
      if (t == 15) chk("lvl0_c15", btn_level[0], 0);
      if (t == 16) chk("lvl0_c16", btn_level[0], 1);
      if (t == 17) chk("valid_c17", cmd_valid, 0);
      if (t == 18) begin
        chk("valid_c18", cmd_valid, 1);
        chk("id_c18", cmd_id, 0);
        chk("rpt_c18", cmd_repeat, 0);
      end
      step();
    end
    btn = '0;
    run(30);
    chk("single_cmd_count", log_id.size(), 1);

    // Bounce, then stable hold, then a short glitch
    n0 = log_id.size();
    for (int k = 0; k < 20; k++) begin
      btn[2] = (k % 2 == 0);
      run(2);
    end
    chk("bounce_no_cmd", log_id.size(), n0);
    btn[2] = 1'b1;
    run(30);
    chk("bounce_press_count", log_id.size(), n0 + 1);
    chk("bounce_press_id", log_id[n0], 2);
    chk("bounce_press_rpt", log_rpt[n0], 0);
    btn[2] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) btn[2] = 1'b1;
      chk("glitch_level_held", btn_level[2], 1);
      step();
    end
    btn = '0;
    run(30);
    chk("glitch_no_new_cmd", log_id.size(), n0 + 1);

    // Auto-repeat on button 1: press + 5 repeats
    btn = 5'b00010;
    guard = 0;
    while (btn_level[1] !== 1'b1 && guard < 40) begin step(); guard++; end
    chk("b1_rise_in_time", btn_level[1], 1);
    n0 = log_id.size();
    run(97);
    btn = '0;
    run(40);
    chk("b1_cmd_count", log_id.size(), n0 + 6);
    for (int j = 0; j < 6; j++) begin
      chk("b1_id", log_id[n0 + j], 1);
      chk("b1_rpt_flag", log_rpt[n0 + j], (j > 0) ? 1 : 0);
    end
    chk("b1_first_gap", log_t[n0 + 1] - log_t[n0], 2 * HOLD - 1);
    for (int j = 2; j < 6; j++) chk("b1_rpt_gap", log_t[n0 + j] - log_t[n0 + j - 1], 2 * RPT);

    // Button 4 never repeats
    n0 = log_id.size();
    btn = 5'b10000;
    run(150);
    btn = '0;
    run(30);
    chk("b4_cmd_count", log_id.size(), n0 + 1);
    chk("b4_id", log_id[n0], 4);
    chk("b4_rpt", log_rpt[n0], 0);

    // Simultaneous presses: round-robin order, one per cycle
    n0 = log_id.size();
    btn = 5'b11001;
    run(40);
    btn = '0;
    run(30);
    chk("sim3_count", log_id.size(), n0 + 3);
    chk("sim3_id0", log_id[n0], 0);
    chk("sim3_id1", log_id[n0 + 1], 3);
    chk("sim3_id2", log_id[n0 + 2], 4);
    chk("sim3_b2b_a", log_t[n0 + 1] - log_t[n0], 1);
    chk("sim3_b2b_b", log_t[n0 + 2] - log_t[n0 + 1], 1);
    n0 = log_id.size();
    btn = 5'b01001;
    run(40);
    btn = '0;
    run(30);
    chk("sim2_count", log_id.size(), n0 + 2);
    chk("sim2_id0", log_id[n0], 0);
    chk("sim2_id1", log_id[n0 + 1], 3);

    // Backpressure: hold output, fill pending, then drop
    rdy = 1'b0; btn = 5'b00010;
    n0 = log_id.size(); d0 = drop_cnt; guard = 0; have = 0; hid = '0; hr = 1'b0;
    while (drop_cnt == d0 && guard < 200) begin
      if (cmd_valid === 1'b1) begin
        if (!have) begin hid = cmd_id; hr = cmd_repeat; have = 1; end
        else begin
          chk("bp_id_stable", cmd_id, hid);
          chk("bp_rpt_stable", cmd_repeat, hr);
        end
      end
      step();
      guard++;
    end
    chk("bp_drop_seen", drop_cnt - d0, 1);
    chk("bp_held_id", hid, 1);
    chk("bp_held_rpt", hr, 0);
    step();
    chk("bp_drop_one_cycle", drop_cnt - d0, 1);
    btn = '0;
    run(40);
    rdy = 1'b1;
    run(10);
    chk("bp_drain_count", log_id.size(), n0 + 2);
    chk("bp_drain_id0", log_id[n0], 1);
    chk("bp_drain_rpt0", log_rpt[n0], 0);
    chk("bp_drain_id1", log_id[n0 + 1], 1);
    chk("bp_drain_rpt1", log_rpt[n0 + 1], 1);

    // Reset with a command on the output and a pending slot
    rdy = 1'b0; btn = 5'b01001;
    run(25);
    chk("mid_valid_before", cmd_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_id", cmd_id, 0);
    chk("mid_rst_rpt", cmd_repeat, 0);
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_drop", drop_pulse, 0);
    rst = 1'b0; btn = '0; rdy = 1'b1;
    n0 = log_id.size();
    run(40);
    chk("mid_rst_no_stale", log_id.size(), n0);

    // Random stimulus against the model
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 15) == 0) begin b = $urandom_range(0, N - 1); btn[b] = ~btn[b]; end
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 63) == 0) begin b = $urandom_range(0, N - 1); btn[b] = ~btn[b]; end
      rdy = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
